// File: rtl/truth_table_scanner_if.sv
// Bundles the start/result handshake and the A-D / F exercise-circuit wiring.
// The slave side is the scanner; the master side drives start and the circuit output F.
interface truth_table_scanner_if;
  logic        start;
  logic        F;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  logic        fail_valid;

  modport master (
    output start, F,
    input  A, B, C, D, busy, done, pass, tt, mismatch_count, first_fail, fail_valid
  );

  modport slave (
    input  start, F,
    output A, B, C, D, busy, done, pass, tt, mismatch_count, first_fail, fail_valid
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 {A,B,C,D} vectors, samples F after SETTLE cycles per vector,
// and compares the captured truth table against the EXPECTED mask.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h0DD0
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t      state, state_next;
  logic [3:0]  idx, idx_next;
  logic [3:0]  cnt, cnt_next;
  logic [15:0] tt, tt_next;
  logic [4:0]  mc, mc_next;
  logic [3:0]  ff, ff_next;
  logic        fv, fv_next;
  logic        pass, pass_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      tt    <= '0;
      mc    <= '0;
      ff    <= '0;
      fv    <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      tt    <= tt_next;
      mc    <= mc_next;
      ff    <= ff_next;
      fv    <= fv_next;
      pass  <= pass_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    tt_next    = tt;
    mc_next    = mc;
    ff_next    = ff;
    fv_next    = fv;
    pass_next  = pass;
    case (state)
      IDLE, DONE: begin
        // A start from DONE is a rescan and discards the previous results.
        if (bus.start) begin
          state_next = APPLY;
          idx_next   = '0;
          cnt_next   = '0;
          tt_next    = '0;
          mc_next    = '0;
          ff_next    = '0;
          fv_next    = 1'b0;
          pass_next  = 1'b0;
        end
      end
      APPLY: begin
        if (cnt != LAST_CNT) begin
          cnt_next = cnt + 4'd1;
        end else begin
          tt_next[idx] = bus.F;
          if (bus.F != EXPECTED[idx]) begin
            mc_next = mc + 5'd1;
            if (!fv) begin
              ff_next = idx;
              fv_next = 1'b1;
            end
          end
          cnt_next = '0;
          // pass must see the bit captured on this final edge, hence tt_next.
          if (idx == 4'd15) begin
            state_next = DONE;
            pass_next  = (tt_next == EXPECTED);
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.A              = (state == APPLY) ? idx[3] : 1'b0;
  assign bus.B              = (state == APPLY) ? idx[2] : 1'b0;
  assign bus.C              = (state == APPLY) ? idx[1] : 1'b0;
  assign bus.D              = (state == APPLY) ? idx[0] : 1'b0;
  assign bus.busy           = (state == APPLY);
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass;
  assign bus.tt             = tt;
  assign bus.mismatch_count = mc;
  assign bus.first_fail     = ff;
  assign bus.fail_valid     = fv;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE 1/2/3) driven by a
// configurable exercise circuit, checked against a truth-table reference model.
module tb_truth_table_scanner;

  localparam logic [15:0] GOLDEN = 16'h0DD0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_scanner_if bus1();
  truth_table_scanner_if bus2();
  truth_table_scanner_if bus3();

  truth_table_scanner #(.SETTLE(1), .EXPECTED(GOLDEN)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  truth_table_scanner #(.SETTLE(2), .EXPECTED(GOLDEN)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  truth_table_scanner #(.SETTLE(3), .EXPECTED(GOLDEN)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Exercise circuit: truth table cur_tab, optionally delayed by one register.
  logic [15:0] cur_tab;
  logic        regd;
  logic [3:0]  vec1, vec2, vec3;
  logic        f_reg1, f_reg2, f_reg3;

  assign vec1 = {bus1.A, bus1.B, bus1.C, bus1.D};
  assign vec2 = {bus2.A, bus2.B, bus2.C, bus2.D};
  assign vec3 = {bus3.A, bus3.B, bus3.C, bus3.D};

  always @(posedge clk) begin
    f_reg1 <= cur_tab[vec1];
    f_reg2 <= cur_tab[vec2];
    f_reg3 <= cur_tab[vec3];
  end

  assign bus1.F = regd ? f_reg1 : cur_tab[vec1];
  assign bus2.F = regd ? f_reg2 : cur_tab[vec2];
  assign bus3.F = regd ? f_reg3 : cur_tab[vec3];

  typedef struct {
    logic        busy;
    logic        done;
    logic        pass;
    logic        fv;
    logic [3:0]  vec;
    logic [15:0] tt;
    logic [4:0]  mc;
    logic [3:0]  ff;
  } out_t;

  typedef struct {
    int          sel;
    int          fmode;
    bit          reg_dut;
    logic [15:0] exp_tt;
    logic [4:0]  exp_mc;
    logic [3:0]  exp_ff;
    bit          exp_fv;
    bit          exp_pass;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic read_out(input int sel, output out_t o);
    case (sel)
      0: o = '{bus1.busy, bus1.done, bus1.pass, bus1.fail_valid, vec1, bus1.tt, bus1.mismatch_count, bus1.first_fail};
      1: o = '{bus2.busy, bus2.done, bus2.pass, bus2.fail_valid, vec2, bus2.tt, bus2.mismatch_count, bus2.first_fail};
      default: o = '{bus3.busy, bus3.done, bus3.pass, bus3.fail_valid, vec3, bus3.tt, bus3.mismatch_count, bus3.first_fail};
    endcase
  endtask

  task automatic apply_stimulus(input int sel, input logic v);
    case (sel)
      0: bus1.start = v;
      1: bus2.start = v;
      default: bus3.start = v;
    endcase
  endtask

  task automatic set_tab(input int fmode);
    int a, b, c, d;
    case (fmode)
      0: for (int v = 0; v < 16; v++) begin
           a = (v >> 3) & 1;
           b = (v >> 2) & 1;
           c = (v >> 1) & 1;
           d = v & 1;
           cur_tab[v] = 1'((a ^ b) & (c | (1 - d)));
         end
      1: cur_tab = 16'h0000;
      default: cur_tab = 16'hFFFF;
    endcase
  endtask

  // Truth table the scanner should capture: a registered circuit with
  // SETTLE=1 shows the value of the previous vector (vector 0 when idle).
  function automatic logic [15:0] model_tt(input logic [15:0] tab, input bit r, input int s);
    logic [15:0] t;
    int src;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      src = (r && s == 1) ? ((i == 0) ? 0 : i - 1) : i;
      t[i] = tab[src];
    end
    return t;
  endfunction

  function automatic int model_first_fail(input logic [15:0] t);
    for (int i = 0; i < 16; i++)
      if (t[i] != GOLDEN[i]) return i;
    return 0;
  endfunction

  // Pulses start, optionally pokes start again while vector poke_idx is shown,
  // and follows the scan to done, checking busy length and the A-D walk.
  task automatic do_scan(input int sel, input string name, input int poke_idx,
                         output out_t first, output out_t res);
    int s, bcnt, werr;
    bit poked;
    out_t o;
    s = sel + 1;
    bcnt = 0;
    werr = 0;
    poked = 0;
    @(negedge clk);
    apply_stimulus(sel, 1'b1);
    @(negedge clk);
    apply_stimulus(sel, 1'b0);
    read_out(sel, first);
    for (int c = 0; c < 16 * s + 20; c++) begin
      read_out(sel, o);
      if (o.done) break;
      if (o.busy) begin
        if (o.vec != 4'(bcnt / s)) werr++;
        bcnt++;
        if (poke_idx >= 0 && !poked && int'(o.vec) == poke_idx) begin
          apply_stimulus(sel, 1'b1);
          poked = 1;
        end else begin
          apply_stimulus(sel, 1'b0);
        end
      end
      @(negedge clk);
    end
    apply_stimulus(sel, 1'b0);
    read_out(sel, res);
    check_output({name, "_done"}, 32'(res.done), 32'd1);
    check_output({name, "_busy_cycles"}, 32'(bcnt), 32'(16 * s));
    check_output({name, "_walk_errors"}, 32'(werr), 32'd0);
    check_output({name, "_vec_after"}, 32'(res.vec), 32'd0);
  endtask

  task automatic check_results(input string name, input out_t o, input logic [15:0] e_tt,
                               input logic [4:0] e_mc, input logic [3:0] e_ff,
                               input bit e_fv, input bit e_pass);
    check_output({name, "_tt"}, 32'(o.tt), 32'(e_tt));
    check_output({name, "_mismatch_count"}, 32'(o.mc), 32'(e_mc));
    check_output({name, "_fail_valid"}, 32'(o.fv), 32'(e_fv));
    check_output({name, "_pass"}, 32'(o.pass), 32'(e_pass));
    if (e_fv) check_output({name, "_first_fail"}, 32'(o.ff), 32'(e_ff));
  endtask

  vec_t vecs[6];
  string names[6];

  initial begin
    out_t o, first, res, prev;
    logic [15:0] m_tt;
    int sel;
    bit found;

    vecs[0] = '{0, 0, 1'b0, 16'h0DD0, 5'd0,  4'd0, 1'b0, 1'b1};
    vecs[1] = '{0, 1, 1'b0, 16'h0000, 5'd6,  4'd4, 1'b1, 1'b0};
    vecs[2] = '{2, 2, 1'b0, 16'hFFFF, 5'd10, 4'd0, 1'b1, 1'b0};
    vecs[3] = '{0, 0, 1'b1, 16'h1BA0, 5'd6,  4'd4, 1'b1, 1'b0};
    vecs[4] = '{1, 0, 1'b1, 16'h0DD0, 5'd0,  4'd0, 1'b0, 1'b1};
    vecs[5] = '{2, 0, 1'b0, 16'h0DD0, 5'd0,  4'd0, 1'b0, 1'b1};
    names = '{"comb_s1", "stuck0_s1", "stuck1_s3", "reg_s1", "reg_s2", "comb_s3"};

    rst = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    bus3.start = 1'b0;
    regd = 1'b0;
    set_tab(0);
    repeat (3) @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      read_out(s, o);
      check_output($sformatf("reset%0d_busy", s), 32'(o.busy), 32'd0);
      check_output($sformatf("reset%0d_done", s), 32'(o.done), 32'd0);
      check_output($sformatf("reset%0d_vec", s), 32'(o.vec), 32'd0);
      check_output($sformatf("reset%0d_results", s),
                   {o.tt, 3'b0, o.mc, o.ff, o.pass, o.fv, 2'b0}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_tab(vecs[i].fmode);
      regd = vecs[i].reg_dut;
      do_scan(vecs[i].sel, names[i], -1, first, res);
      check_output({names[i], "_first_vec"}, 32'(first.vec), 32'd0);
      check_results(names[i], res, vecs[i].exp_tt, vecs[i].exp_mc, vecs[i].exp_ff,
                    vecs[i].exp_fv, vecs[i].exp_pass);
    end

    for (int i = 0; i < 8; i++) begin
      cur_tab = 16'($urandom);
      regd = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 2));
      m_tt = model_tt(cur_tab, regd, sel + 1);
      do_scan(sel, $sformatf("rand%0d", i), -1, first, res);
      check_results($sformatf("rand%0d", i), res, m_tt, 5'($countones(m_tt ^ GOLDEN)),
                    4'(model_first_fail(m_tt)), (m_tt != GOLDEN), (m_tt == GOLDEN));
    end

    // Reset while vector 7 is applied.
    set_tab(0);
    regd = 1'b0;
    @(negedge clk);
    apply_stimulus(0, 1'b1);
    @(negedge clk);
    apply_stimulus(0, 1'b0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      read_out(0, o);
      if (o.busy && o.vec == 4'd7) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_output("midreset_reached_idx7", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    read_out(0, o);
    check_output("midreset_vec", 32'(o.vec), 32'd0);
    check_output("midreset_busy", 32'(o.busy), 32'd0);
    check_output("midreset_done", 32'(o.done), 32'd0);
    check_output("midreset_tt", 32'(o.tt), 32'd0);
    check_output("midreset_mismatch_count", 32'(o.mc), 32'd0);
    do_scan(0, "after_reset", -1, first, res);
    check_results("after_reset", res, 16'h0DD0, 5'd0, 4'd0, 1'b0, 1'b1);

    // Start while busy is ignored; the rescan clears done and tt on its start edge.
    set_tab(1);
    do_scan(0, "poke", 3, first, prev);
    check_results("poke", prev, 16'h0000, 5'd6, 4'd4, 1'b1, 1'b0);
    do_scan(0, "rescan", -1, first, res);
    check_output("rescan_done_drop", 32'(first.done), 32'd0);
    check_output("rescan_busy_rise", 32'(first.busy), 32'd1);
    check_output("rescan_tt_cleared", 32'(first.tt), 32'd0);
    check_output("rescan_same_tt", 32'(res.tt), 32'(prev.tt));
    check_output("rescan_same_counts", {res.mc, res.ff, res.fv, res.pass}, {prev.mc, prev.ff, prev.fv, prev.pass});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
